// File: rtl/vram_port_arbiter_if.sv
// Aux host port of vram_port_arbiter: posted writes, in-order reads with a separate return pulse.
interface vram_port_arbiter_if #(
  parameter int ADDR_W = 15
) ();
  // Handshake: the master raises aux_req with aux_we/aux_adr/aux_wdata stable and holds all
  // of them until a cycle with aux_ack=1; the transfer is accepted at that clock edge. Read
  // data returns later as a one-cycle aux_rvalid with aux_rdata, with no backpressure.
  logic              aux_req;
  logic              aux_we;
  logic [ADDR_W-1:0] aux_adr;
  logic [7:0]        aux_wdata;
  logic              aux_ack;
  logic [7:0]        aux_rdata;
  logic              aux_rvalid;

  modport master (
    output aux_req, aux_we, aux_adr, aux_wdata,
    input  aux_ack, aux_rdata, aux_rvalid
  );

  modport slave (
    input  aux_req, aux_we, aux_adr, aux_wdata,
    output aux_ack, aux_rdata, aux_rvalid
  );
endinterface

// File: rtl/vram_port_arbiter.sv
// Shares single-port VRAM between the VDP (owns every slot cycle) and an aux host port.
// Optional power-up VRAM clear engine enabled by defining VRAM_CLEAR_EN.
module vram_port_arbiter #(
  parameter int ADDR_W      = 15,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n_w,
  input  logic              vdp_slot,
  input  logic              vdp_we_n,
  input  logic [ADDR_W-1:0] vdp_adr,
  input  logic [7:0]        vdp_wdata,
  output logic [7:0]        vdp_rdata,
  vram_port_arbiter_if.slave aux,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout,
  output logic              clr_busy,
  output logic [1:0]        dbg_state
);
  localparam int              PTR_W    = $clog2(WFIFO_DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(WFIFO_DEPTH);

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_RD_WAIT_FIFO = 2'd1;
  localparam logic [1:0] ST_RD_ISSUE     = 2'd2;
  localparam logic [1:0] ST_RD_DATA      = 2'd3;

  logic [1:0]        state_r, state_nxt;
  logic [ADDR_W-1:0] fifo_adr [WFIFO_DEPTH];
  logic [7:0]        fifo_dat [WFIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count_r;
  logic              fifo_empty, fifo_full;
  logic              aux_open, push, pop, rd_issue;
  logic              slot_d;
  logic [7:0]        hold_r;
  logic [7:0]        aux_rdata_r;
  logic              aux_rvalid_r;
  logic              clr_wr;
  logic [ADDR_W-1:0] clr_adr;

`ifdef VRAM_CLEAR_EN
  logic              clr_busy_r;
  logic [ADDR_W-1:0] clr_adr_r;

  // Zero-fill sweeps every address once after reset, using free cycles only.
  always_ff @(posedge clk or negedge rst_n_w) begin
    if (!rst_n_w) begin
      clr_busy_r <= 1'b1;
      clr_adr_r  <= '0;
    end else if (clr_busy_r && !vdp_slot) begin
      clr_adr_r <= clr_adr_r + 1'b1;
      if (&clr_adr_r) clr_busy_r <= 1'b0;
    end
  end

  assign clr_busy = clr_busy_r;
  assign clr_wr   = clr_busy_r & ~vdp_slot;
  assign clr_adr  = clr_adr_r;
`else
  assign clr_busy = 1'b0;
  assign clr_wr   = 1'b0;
  assign clr_adr  = '0;
`endif

  assign fifo_empty = (count_r == '0);
  assign fifo_full  = (count_r == FULL_CNT);
  assign aux_open   = rst_n_w & ~clr_busy;
  assign push       = aux_open & aux.aux_req & aux.aux_we & ~fifo_full & (state_r == ST_IDLE);
  assign pop        = aux_open & ~vdp_slot & ~fifo_empty;
  assign rd_issue   = aux_open & ~vdp_slot & (state_r == ST_RD_ISSUE);

  assign aux.aux_ack    = push | rd_issue;
  assign aux.aux_rdata  = aux_rdata_r;
  assign aux.aux_rvalid = aux_rvalid_r;
  assign dbg_state      = state_r;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_adr[wr_ptr] <= aux.aux_adr;
      fifo_dat[wr_ptr] <= aux.aux_wdata;
    end
  end

  // A full FIFO refuses the push even when it pops in the same cycle.
  always_ff @(posedge clk or negedge rst_n_w) begin
    if (!rst_n_w) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE:         if (aux_open && aux.aux_req && !aux.aux_we) state_nxt = ST_RD_WAIT_FIFO;
      ST_RD_WAIT_FIFO: if (fifo_empty) state_nxt = ST_RD_ISSUE;
      ST_RD_ISSUE:     if (rd_issue) state_nxt = ST_RD_DATA;
      ST_RD_DATA:      state_nxt = ST_IDLE;
      default:         state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_w) begin
    if (!rst_n_w) begin
      state_r      <= ST_IDLE;
      aux_rdata_r  <= 8'h00;
      aux_rvalid_r <= 1'b0;
    end else begin
      state_r      <= state_nxt;
      aux_rvalid_r <= (state_r == ST_RD_DATA);
      if (state_r == ST_RD_DATA) aux_rdata_r <= ram_dout;
    end
  end

  // The VDP sees live RAM data only right after its own slot; otherwise the held copy.
  always_ff @(posedge clk or negedge rst_n_w) begin
    if (!rst_n_w) begin
      slot_d <= 1'b0;
      hold_r <= 8'h00;
    end else begin
      slot_d <= vdp_slot;
      if (slot_d) hold_r <= ram_dout;
    end
  end

  assign vdp_rdata = slot_d ? ram_dout : hold_r;

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = vdp_adr;
    ram_din  = vdp_wdata;
    if (vdp_slot) begin
      ram_we = ~vdp_we_n;
    end else if (clr_wr) begin
      ram_we   = 1'b1;
      ram_addr = clr_adr;
      ram_din  = 8'h00;
    end else if (pop) begin
      ram_we   = 1'b1;
      ram_addr = fifo_adr[rd_ptr];
      ram_din  = fifo_dat[rd_ptr];
    end else if (rd_issue) begin
      ram_addr = aux.aux_adr;
    end
    if (!rst_n_w) ram_we = 1'b0;
  end
endmodule
